// File: rtl/acumulador_bloco.sv
// Block accumulator: sums COUNT samples from the upstream adder and presents the total
// on a valid/ready port. Optional macro ACUM_SATURATE_EN clamps the total instead of wrapping.
module acumulador_bloco #(
    parameter int WIDTH = 44,
    parameter int COUNT = 8,
    parameter int CNT_W = 4
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             clear,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] in_data,
    output logic             in_ready,
    output logic             out_valid,
    output logic [WIDTH-1:0] out_data,
    input  logic             out_ready,
    output logic             overflow,
    output logic [CNT_W-1:0] count
);

    typedef enum logic {ACC = 1'b0, DONE = 1'b1} state_t;

    localparam logic [CNT_W-1:0] LAST = CNT_W'(COUNT - 1);

    state_t           state, state_nxt;
    logic [WIDTH-1:0] acc, acc_nxt;
    logic             ovf, ovf_nxt;
    logic [CNT_W-1:0] cnt, cnt_nxt;
    logic [WIDTH:0]   sum;
    logic [WIDTH-1:0] acc_add;
    logic             accept, take, last;

    // FSM: state register
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) state <= ACC;
        else          state <= state_nxt;
    end

    // FSM: next state; clear overrides both the final accept and the output handshake
    always_comb begin
        state_nxt = state;
        if (clear) begin
            state_nxt = ACC;
        end else begin
            case (state)
                ACC:     if (accept && last) state_nxt = DONE;
                DONE:    if (take)           state_nxt = ACC;
                default: state_nxt = ACC;
            endcase
        end
    end

    // FSM: outputs
    always_comb begin
        in_ready  = (state == ACC) && !clear;
        out_valid = (state == DONE);
    end

    assign accept = in_valid && in_ready;
    assign take   = out_valid && out_ready;
    assign last   = (cnt == LAST);
    assign sum    = {1'b0, acc} + {1'b0, in_data};

`ifdef ACUM_SATURATE_EN
    // A saturated acc stays all-ones: any further nonzero add carries again.
    assign acc_add = sum[WIDTH] ? {WIDTH{1'b1}} : sum[WIDTH-1:0];
`else
    assign acc_add = sum[WIDTH-1:0];
`endif

    always_comb begin
        acc_nxt = acc;
        ovf_nxt = ovf;
        cnt_nxt = cnt;
        if (clear) begin
            acc_nxt = '0;
            ovf_nxt = 1'b0;
            cnt_nxt = '0;
        end else if (accept) begin
            acc_nxt = acc_add;
            ovf_nxt = ovf | sum[WIDTH];
            cnt_nxt = last ? '0 : cnt + CNT_W'(1);
        end else if (take) begin
            acc_nxt = '0;
            ovf_nxt = 1'b0;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            acc <= '0;
            ovf <= 1'b0;
            cnt <= '0;
        end else begin
            acc <= acc_nxt;
            ovf <= ovf_nxt;
            cnt <= cnt_nxt;
        end
    end

    assign out_data = acc;
    assign overflow = ovf;
    assign count    = cnt;

endmodule

// File: tb/tb_acumulador_bloco.sv
// Bench for acumulador_bloco: directed scenarios plus random traffic, all checked every
// cycle against a sum-of-samples model of the block.
module tb_acumulador_bloco;

    localparam int WIDTH = 44;
    localparam int COUNT = 8;
    localparam int CNT_W = 4;
    localparam logic [63:0] MAXV = 64'h0000_0FFF_FFFF_FFFF;

    logic             clock = 1'b0;
    logic             reset_n = 1'b1;
    logic             clear = 1'b0;
    logic             in_valid = 1'b0;
    logic [WIDTH-1:0] in_data = '0;
    logic             in_ready;
    logic             out_valid;
    logic [WIDTH-1:0] out_data;
    logic             out_ready = 1'b0;
    logic             overflow;
    logic [CNT_W-1:0] count;

    int total = 0;
    int bad   = 0;

    acumulador_bloco #(.WIDTH(WIDTH), .COUNT(COUNT), .CNT_W(CNT_W)) dut (
        .clock(clock), .reset_n(reset_n), .clear(clear),
        .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
        .out_valid(out_valid), .out_data(out_data), .out_ready(out_ready),
        .overflow(overflow), .count(count)
    );

    always #5 clock = ~clock;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Model: true (unbounded) sum of the samples taken into the current block.
    logic [63:0] m_sum  = '0;
    int          m_cnt  = 0;
    logic        m_done = 1'b0;

    always @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            m_sum <= '0; m_cnt <= 0; m_done <= 1'b0;
        end else if (clear) begin
            m_sum <= '0; m_cnt <= 0; m_done <= 1'b0;
        end else if (m_done) begin
            if (out_ready) begin m_sum <= '0; m_done <= 1'b0; end
        end else if (in_valid) begin
            m_sum <= m_sum + 64'(in_data);
            if (m_cnt == COUNT - 1) begin m_cnt <= 0; m_done <= 1'b1; end
            else m_cnt <= m_cnt + 1;
        end
    end

    function automatic logic [63:0] exp_acc(input logic [63:0] s);
`ifdef ACUM_SATURATE_EN
        return (s > MAXV) ? MAXV : s;
`else
        return s & MAXV;
`endif
    endfunction

    always @(negedge clock) begin
        check("in_ready",  64'(in_ready),  64'(!m_done && !clear));
        check("out_valid", 64'(out_valid), 64'(m_done));
        check("count",     64'(count),     64'(m_cnt));
        check("out_data",  64'(out_data),  exp_acc(m_sum));
        check("overflow",  64'(overflow),  64'(m_sum > MAXV));
    end

    task automatic step();
        @(posedge clock); #1;
    endtask

    task automatic send(input logic [WIDTH-1:0] d);
        in_valid = 1'b1; in_data = d;
        step();
    endtask

    initial begin
        int samples[8] = '{12, 51, 9, 100, 12, 51, 9, 100};
        #1 reset_n = 1'b0;
        in_valid = 1'b1; in_data = 44'd5;
        repeat (3) step();
        check("rst out_valid", 64'(out_valid), 64'd0);
        check("rst out_data",  64'(out_data),  64'd0);
        check("rst count",     64'(count),     64'd0);
        check("rst overflow",  64'(overflow),  64'd0);
        reset_n = 1'b1; in_valid = 1'b0;
        check("rel in_ready", 64'(in_ready), 64'd1);
        step();

        // Back-to-back block of 8
        out_ready = 1'b1;
        foreach (samples[i]) send(44'(samples[i]));
        in_valid = 1'b0;
        check("blk out_valid", 64'(out_valid), 64'd1);
        check("blk out_data",  64'(out_data),  64'd344);
        check("blk overflow",  64'(overflow),  64'd0);
        step();
        check("blk taken valid", 64'(out_valid), 64'd0);
        check("blk taken acc",   64'(out_data),  64'd0);

        // Backpressure with in_valid asserted while the total waits
        out_ready = 1'b0;
        foreach (samples[i]) send(44'(samples[i]));
        in_valid = 1'b1; in_data = 44'd77;
        repeat (5) begin
            check("bp in_ready", 64'(in_ready), 64'd0);
            check("bp out_data", 64'(out_data), 64'd344);
            check("bp count",    64'(count),    64'd0);
            step();
        end
        in_valid = 1'b0; out_ready = 1'b1;
        step();
        repeat (8) send(44'd10);
        in_valid = 1'b0;
        check("bp next block", 64'(out_data), 64'd80);
        step();

        // Carry out of WIDTH bits
        send(44'(MAXV));
        send(44'd2);
        repeat (6) send(44'd0);
        in_valid = 1'b0;
`ifdef ACUM_SATURATE_EN
        check("ovf out_data", 64'(out_data), MAXV);
`else
        check("ovf out_data", 64'(out_data), 64'd1);
`endif
        check("ovf flag", 64'(overflow), 64'd1);
        step();
        check("ovf cleared", 64'(overflow), 64'd0);
        check("ovf acc zero", 64'(out_data), 64'd0);

        // clear mid-block drops the sample presented with it
        send(44'd4); send(44'd8); send(44'd11);
        check("pre-clear count", 64'(count), 64'd3);
        clear = 1'b1;
        send(44'd40);
        clear = 1'b0;
        check("clear count", 64'(count),    64'd0);
        check("clear acc",   64'(out_data), 64'd0);
        repeat (8) send(44'd5);
        in_valid = 1'b0;
        check("after clear", 64'(out_data), 64'd40);
        step();

        // Async reset while a total is waiting
        out_ready = 1'b0;
        repeat (8) send(44'd1);
        in_valid = 1'b0;
        check("done before rst", 64'(out_valid), 64'd1);
        @(posedge clock); #2 reset_n = 1'b0;
        #1 check("async drop", 64'(out_valid), 64'd0);
        step();
        reset_n = 1'b1; out_ready = 1'b1;
        repeat (8) send(44'd3);
        in_valid = 1'b0;
        check("post-rst block", 64'(out_data), 64'd24);
        step();

        // Random traffic
        for (int c = 0; c < 600; c++) begin
            in_valid  = ($urandom_range(3) != 0);
            in_data   = ($urandom_range(3) == 0) ? 44'(MAXV - 64'($urandom_range(7)))
                                                 : 44'({$urandom, $urandom});
            out_ready = ($urandom_range(1) == 1);
            clear     = ($urandom_range(31) == 0);
            step();
        end
        clear = 1'b0; in_valid = 1'b0;
        step();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
